width_decoder: RTL and testbench
================================

WIDTH_DECODER -- requirements
Module: width_decoder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), reset input 1 (synchronous active-high reset).
REQ-002 The block SHALL have port funct3, input, 3 bits: instruction funct3 field.
REQ-003 The block SHALL have port WidthOp, input, 1 bit: 1 = load/store instruction, funct3 selects the access width; 0 = non-memory instruction.
REQ-004 The block SHALL have port en, input, 1 bit: register-stage enable; 0 = stall.
REQ-005 The block SHALL have port flush, input, 1 bit: clears the register stage.
REQ-006 The block SHALL have port WidthSrc, output, 3 bits: combinational width code.
REQ-007 The block SHALL have port WidthIllegal, output, 1 bit: combinational flag; WidthOp=1 with an unsupported funct3.
REQ-008 The block SHALL have port WidthSrcR, output, 3 bits: registered copy of WidthSrc.
REQ-009 The block SHALL have port WidthIllegalR, output, 1 bit: registered copy of WidthIllegal.

Function
REQ-010 Width code format SHALL be: bit2 = unsigned; bits[1:0] = 00 word, 01 byte, 10 half.
REQ-011 When WidthOp=0, WidthSrc SHALL be 000 and WidthIllegal SHALL be 0 for all 8 funct3 values.
REQ-012 When WidthOp=1, the decode SHALL be: funct3 010 -> 000 (word).
REQ-013 When WidthOp=1, the decode SHALL be: 001 -> 010 (half, signed).
REQ-014 When WidthOp=1, the decode SHALL be: 000 -> 001 (byte, signed).
REQ-015 When WidthOp=1, the decode SHALL be: 101 -> 110 (half, unsigned).
REQ-016 When WidthOp=1, the decode SHALL be: 100 -> 101 (byte, unsigned).
REQ-017 When WidthOp=1 and funct3 is 011, 110 or 111, WidthSrc SHALL be 000 (never X) and WidthIllegal SHALL be 1.
REQ-018 WidthSrc and WidthIllegal SHALL be purely combinational: valid in the same cycle as the inputs, zero latency, no dependence on clk or reset.
REQ-019 Output values 011, 100 and 111 SHALL never be produced on WidthSrc.
REQ-020 On each rising clk edge with reset=0, flush=0 and en=1, WidthSrcR and WidthIllegalR SHALL load the current WidthSrc and WidthIllegal (latency 1 cycle).
REQ-021 With reset=0, flush=0 and en=0, WidthSrcR and WidthIllegalR SHALL hold their values.
REQ-022 With reset=0 and flush=1, WidthSrcR SHALL load 000 and WidthIllegalR SHALL load 0 on the edge, regardless of en.
REQ-023 Store instructions SHALL use the same decode; funct3 000/001/010 give byte/half/word, and the signedness bit is ignored downstream.

Reset
REQ-024 Synchronous reset=1 at a rising edge SHALL set WidthSrcR=000 and WidthIllegalR=0; reset SHALL take priority over flush, then flush over en.
REQ-025 Reset SHALL NOT affect the combinational outputs WidthSrc and WidthIllegal.
REQ-026 Reset asserted mid-stall SHALL clear the held registered values on the next edge.

Verification
REQ-027 Scenario: WidthOp=0 with funct3 swept 0..7 -> WidthSrc=000 and WidthIllegal=0 every time.
REQ-028 Scenario: WidthOp=1 with funct3 = 010, 001, 000, 101, 100 -> WidthSrc = 000, 010, 001, 110, 101 respectively, with WidthIllegal=0.
REQ-029 Scenario: WidthOp=1 with funct3 = 011, 110, 111 -> WidthSrc=000 and WidthIllegal=1; no X/Z on any output.
REQ-030 Scenario: reset=1 for one edge, then WidthOp=1, funct3=101, en=1 -> WidthSrcR = 000 after the reset edge and 110 after the next edge.
REQ-031 Scenario: WidthSrcR=101, then en=0 with funct3 changed to 001 for 3 edges -> WidthSrcR stays 101; raising en=1 -> WidthSrcR becomes 010 on the next edge.
REQ-032 Scenario: flush=1 and en=1 with funct3=111 and WidthOp=1 -> WidthSrcR=000 and WidthIllegalR=0, while combinational WidthIllegal=1.

Source files
------------

// File: rtl/width_decoder.sv
// Load/store access-width decoder: funct3 -> width code {unsigned, size[1:0]},
// with a combinational result and a stallable, flushable registered copy.
module width_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] funct3,
  input  logic       WidthOp,
  input  logic       en,
  input  logic       flush,
  output logic [2:0] WidthSrc,
  output logic       WidthIllegal,
  output logic [2:0] WidthSrcR,
  output logic       WidthIllegalR
);

  logic [2:0] width_src_q;
  logic       width_illegal_q;
  logic [2:0] width_src_d;
  logic       width_illegal_d;

  // Returns {illegal, code}; unsupported encodings decode to word so the
  // width path never carries X or a reserved code.
  function automatic logic [3:0] decode_width(input logic op, input logic [2:0] f3);
    logic [3:0] res;
    res = 4'b0_000;
    if (op) begin
      case (f3)
        3'b010:  res = 4'b0_000;
        3'b001:  res = 4'b0_010;
        3'b000:  res = 4'b0_001;
        3'b101:  res = 4'b0_110;
        3'b100:  res = 4'b0_101;
        default: res = 4'b1_000;
      endcase
    end
    return res;
  endfunction

  always_comb begin
    {WidthIllegal, WidthSrc} = decode_width(WidthOp, funct3);
  end

  always_comb begin
    width_src_d     = width_src_q;
    width_illegal_d = width_illegal_q;
    if (flush) begin
      width_src_d     = 3'b000;
      width_illegal_d = 1'b0;
    end else if (en) begin
      width_src_d     = WidthSrc;
      width_illegal_d = WidthIllegal;
    end
  end

  // Register stage: reset over flush over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      width_src_q     <= 3'b000;
      width_illegal_q <= 1'b0;
    end else begin
      width_src_q     <= width_src_d;
      width_illegal_q <= width_illegal_d;
    end
  end

  assign WidthSrcR     = width_src_q;
  assign WidthIllegalR = width_illegal_q;

endmodule

// File: tb/tb_width_decoder.sv
// Directed bench for width_decoder: combinational decode table plus
// reset/flush/stall behaviour of the registered copy.
module tb_width_decoder;

  logic       clk;
  logic       reset;
  logic [2:0] funct3;
  logic       WidthOp;
  logic       en;
  logic       flush;
  logic [2:0] WidthSrc;
  logic       WidthIllegal;
  logic [2:0] WidthSrcR;
  logic       WidthIllegalR;

  int checks = 0;
  int errors = 0;

  width_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .funct3        (funct3),
    .WidthOp       (WidthOp),
    .en            (en),
    .flush         (flush),
    .WidthSrc      (WidthSrc),
    .WidthIllegal  (WidthIllegal),
    .WidthSrcR     (WidthSrcR),
    .WidthIllegalR (WidthIllegalR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] legal_f3  [5] = '{3'b010, 3'b001, 3'b000, 3'b101, 3'b100};
  logic [2:0] legal_exp [5] = '{3'b000, 3'b010, 3'b001, 3'b110, 3'b101};
  logic [2:0] bad_f3    [3] = '{3'b011, 3'b110, 3'b111};

  initial begin
    reset = 1'b1; funct3 = 3'b000; WidthOp = 1'b0; en = 1'b0; flush = 1'b0;
    tick();
    chk("reset_regs", {WidthIllegalR, WidthSrcR}, 4'b0_000);

    // Combinational outputs ignore reset
    WidthOp = 1'b1; funct3 = 3'b101; #1;
    chk("comb_during_reset", {WidthIllegal, WidthSrc}, 4'b0_110);
    funct3 = 3'b110; #1;
    chk("comb_illegal_during_reset", {WidthIllegal, WidthSrc}, 4'b1_000);

    reset = 1'b0; WidthOp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      funct3 = 3'(i); #1;
      chk($sformatf("nonmem_f3_%0d", i), {WidthIllegal, WidthSrc}, 4'b0_000);
    end

    WidthOp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      funct3 = legal_f3[i]; #1;
      chk($sformatf("legal_f3_%b", legal_f3[i]), {WidthIllegal, WidthSrc}, {1'b0, legal_exp[i]});
    end
    for (int i = 0; i < 3; i++) begin
      funct3 = bad_f3[i]; #1;
      chk($sformatf("illegal_f3_%b", bad_f3[i]), {WidthIllegal, WidthSrc}, 4'b1_000);
    end

    // Reset edge then one load edge
    reset = 1'b1; en = 1'b1; funct3 = 3'b101;
    tick();
    chk("reset_edge_clears", {WidthIllegalR, WidthSrcR}, 4'b0_000);
    reset = 1'b0;
    tick();
    chk("load_after_reset", {WidthIllegalR, WidthSrcR}, 4'b0_110);

    // Stall holds, release loads
    funct3 = 3'b100;
    tick();
    chk("load_lbu", {WidthIllegalR, WidthSrcR}, 4'b0_101);
    en = 1'b0; funct3 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold_%0d", i), {WidthIllegalR, WidthSrcR}, 4'b0_101);
    end
    en = 1'b1;
    tick();
    chk("stall_release", {WidthIllegalR, WidthSrcR}, 4'b0_010);

    // Reset during a stall clears the held value
    en = 1'b0; funct3 = 3'b100;
    tick();
    chk("hold_before_reset", {WidthIllegalR, WidthSrcR}, 4'b0_010);
    reset = 1'b1;
    tick();
    chk("reset_mid_stall", {WidthIllegalR, WidthSrcR}, 4'b0_000);
    reset = 1'b0;

    // Registered illegal flag, and holding it
    en = 1'b1; funct3 = 3'b111;
    tick();
    chk("load_illegal", {WidthIllegalR, WidthSrcR}, 4'b1_000);
    en = 1'b0; funct3 = 3'b010;
    tick();
    chk("hold_illegal", {WidthIllegalR, WidthSrcR}, 4'b1_000);

    // Flush with en=1 and an illegal funct3
    flush = 1'b1; en = 1'b1; funct3 = 3'b111; #1;
    chk("flush_comb_illegal", {WidthIllegal, WidthSrc}, 4'b1_000);
    tick();
    chk("flush_en1", {WidthIllegalR, WidthSrcR}, 4'b0_000);

    // Flush with en=0 still clears
    flush = 1'b0; funct3 = 3'b101;
    tick();
    chk("load_before_flush", {WidthIllegalR, WidthSrcR}, 4'b0_110);
    flush = 1'b1; en = 1'b0;
    tick();
    chk("flush_en0", {WidthIllegalR, WidthSrcR}, 4'b0_000);

    // Store widths share the decode
    flush = 1'b0; en = 1'b1; funct3 = 3'b001;
    tick();
    chk("store_half_reg", {WidthIllegalR, WidthSrcR}, 4'b0_010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
